// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue controller: default widths,
// FSM state encoding and the rs_data_sel beat identifiers.
package alu_pkg;

    localparam int ALU_BUS_WIDTH    = 32;
    localparam int ALU_OPCODE_WIDTH = 11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_RS1 = 3'd1,
        SEND_RS2 = 3'd2,
        WAIT_ALU = 3'd3,
        WB       = 3'd4
    } alu_ctrl_state_e;

    localparam logic RS_SEL_RS1 = 1'b0;
    localparam logic RS_SEL_RS2 = 1'b1;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of issue, ALU and writeback signals around the issue controller.
// slave = the controller itself, master = decode/ALU/writeback environment.
interface alu_issue_ctrl_if
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH    = ALU_BUS_WIDTH,
    parameter int OPCODE_WIDTH = ALU_OPCODE_WIDTH
) ();

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; the offering side holds its payload stable while valid && !ready.
    logic                    issue_valid;
    logic                    issue_ready;
    logic [OPCODE_WIDTH-1:0] issue_op_code;
    logic [BUS_WIDTH-1:0]    issue_rs1;
    logic [BUS_WIDTH-1:0]    issue_rs2;
    logic [BUS_WIDTH-1:0]    issue_imm;
    logic                    issue_use_imm;
    logic [4:0]              issue_rd;

    logic [BUS_WIDTH-1:0]    imme_value;
    logic [BUS_WIDTH-1:0]    rs_data;
    logic                    rs_data_sel;
    logic                    rs_data_valid;
    logic [OPCODE_WIDTH-1:0] op_code;
    logic [BUS_WIDTH-1:0]    alu_out;
    logic                    alu_valid_out;
    logic                    op_done;

    logic                    wb_valid;
    logic                    wb_ready;
    logic [BUS_WIDTH-1:0]    wb_data;
    logic [4:0]              wb_rd;

    logic                    busy;
    logic                    err_timeout;
    logic                    err_protocol;

    modport slave (
        input  issue_valid, issue_op_code, issue_rs1, issue_rs2, issue_imm,
               issue_use_imm, issue_rd, alu_out, alu_valid_out, op_done, wb_ready,
        output issue_ready, imme_value, rs_data, rs_data_sel, rs_data_valid,
               op_code, wb_valid, wb_data, wb_rd, busy, err_timeout, err_protocol
    );

    modport master (
        output issue_valid, issue_op_code, issue_rs1, issue_rs2, issue_imm,
               issue_use_imm, issue_rd, alu_out, alu_valid_out, op_done, wb_ready,
        input  issue_ready, imme_value, rs_data, rs_data_sel, rs_data_valid,
               op_code, wb_valid, wb_data, wb_rd, busy, err_timeout, err_protocol
    );

endinterface

// File: rtl/alu_wait_timer.sv
// Cycle counter bounding how long the controller waits for op_done.
// Requires TIMEOUT_CYCLES >= 2.
module alu_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one instruction, serializes rs1/rs2 to the ALU,
// waits for the result with a timeout and offers it to writeback.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH      = ALU_BUS_WIDTH,
    parameter int OPCODE_WIDTH   = ALU_OPCODE_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    alu_issue_ctrl_if.slave bus,
    output alu_ctrl_state_e o_dbg_state
);

    alu_ctrl_state_e         r_state;
    alu_ctrl_state_e         w_state_nxt;
    logic                    r_issue_ready;
    logic [OPCODE_WIDTH-1:0] r_op_code;
    logic [BUS_WIDTH-1:0]    r_rs1;
    logic [BUS_WIDTH-1:0]    r_rs2;
    logic [BUS_WIDTH-1:0]    r_imm;
    logic                    r_use_imm;
    logic [4:0]              r_rd;
    logic [BUS_WIDTH-1:0]    r_result;
    logic                    r_result_seen;
    logic                    r_err_timeout;
    logic                    r_err_protocol;

    logic w_accept;
    logic w_in_wait;
    logic w_expired;
    logic w_timeout;
    logic w_protocol;

    assign w_accept   = (r_state == IDLE) && r_issue_ready && bus.issue_valid;
    assign w_in_wait  = (r_state == WAIT_ALU);
    // op_done takes priority over a coincident timeout threshold.
    assign w_timeout  = w_in_wait && !bus.op_done && w_expired;
    assign w_protocol = w_in_wait && bus.op_done && !r_result_seen && !bus.alu_valid_out;

    alu_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (!w_in_wait),
        .i_enable (w_in_wait && !bus.op_done),
        .o_expired(w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_state_nxt = SEND_RS1;
            SEND_RS1: w_state_nxt = r_use_imm ? WAIT_ALU : SEND_RS2;
            SEND_RS2: w_state_nxt = WAIT_ALU;
            WAIT_ALU: begin
                if (bus.op_done) begin
                    w_state_nxt = (r_result_seen || bus.alu_valid_out) ? WB : IDLE;
                end else if (w_expired) begin
                    w_state_nxt = IDLE;
                end
            end
            WB:       if (bus.wb_ready) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_issue_ready  <= 1'b0;
            r_op_code      <= '0;
            r_rs1          <= '0;
            r_rs2          <= '0;
            r_imm          <= '0;
            r_use_imm      <= 1'b0;
            r_rd           <= '0;
            r_result       <= '0;
            r_result_seen  <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_protocol <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_issue_ready  <= (w_state_nxt == IDLE);
            r_err_timeout  <= w_timeout;
            r_err_protocol <= w_protocol;
            if (w_accept) begin
                r_op_code     <= bus.issue_op_code;
                r_rs1         <= bus.issue_rs1;
                r_rs2         <= bus.issue_rs2;
                r_imm         <= bus.issue_imm;
                r_use_imm     <= bus.issue_use_imm;
                r_rd          <= bus.issue_rd;
                r_result_seen <= 1'b0;
            end
            // Several results may arrive before op_done; the last one is kept.
            if (w_in_wait && bus.alu_valid_out) begin
                r_result      <= bus.alu_out;
                r_result_seen <= 1'b1;
            end
        end
    end

    assign o_dbg_state       = r_state;
    assign bus.issue_ready   = r_issue_ready;
    assign bus.busy          = (r_state != IDLE);
    assign bus.op_code       = (r_state != IDLE) ? r_op_code : '0;
    assign bus.imme_value    = (r_state != IDLE) ? r_imm : '0;
    assign bus.rs_data_valid = (r_state == SEND_RS1) || (r_state == SEND_RS2);
    assign bus.rs_data_sel   = (r_state == SEND_RS2) ? RS_SEL_RS2 : RS_SEL_RS1;
    assign bus.rs_data       = (r_state == SEND_RS1) ? r_rs1 :
                               (r_state == SEND_RS2) ? r_rs2 : '0;
    assign bus.wb_valid      = (r_state == WB);
    assign bus.wb_data       = (r_state == WB) ? r_result : '0;
    assign bus.wb_rd         = (r_state == WB) ? r_rd : '0;
    assign bus.err_timeout   = r_err_timeout;
    assign bus.err_protocol  = r_err_protocol;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed and randomized stimulus for alu_issue_ctrl with an emulated ALU
// and a writeback scoreboard.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int BW = 32;
    localparam int OW = 11;
    localparam int TO = 16;

    logic            clk;
    logic            rst;
    alu_ctrl_state_e dbg_state;
    int              checks;
    int              errors;
    logic [BW+4:0]   exp_q[$];

    alu_issue_ctrl_if #(.BUS_WIDTH(BW), .OPCODE_WIDTH(OW)) bus ();

    alu_issue_ctrl #(
        .BUS_WIDTH     (BW),
        .OPCODE_WIDTH  (OW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [BW-1:0] alu_model(input logic [OW-1:0] op,
                                                input logic [BW-1:0] a,
                                                input logic [BW-1:0] b);
        case (op)
            11'd1:   return a + b;
            11'd2:   return a - b;
            11'd3:   return a ^ b;
            default: return a & b;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic issue(input logic [OW-1:0] op, input logic [BW-1:0] rs1,
                         input logic [BW-1:0] rs2, input logic [BW-1:0] imm,
                         input logic use_imm, input logic [4:0] rd, input bit expect_wb);
        int n;
        n = 0;
        bus.issue_op_code = op;
        bus.issue_rs1     = rs1;
        bus.issue_rs2     = rs2;
        bus.issue_imm     = imm;
        bus.issue_use_imm = use_imm;
        bus.issue_rd      = rd;
        bus.issue_valid   = 1'b1;
        while (bus.issue_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("issue_ready_wait", bus.issue_ready, 1);
        tick();
        bus.issue_valid = 1'b0;
        if (expect_wb) exp_q.push_back({rd, alu_model(op, rs1, use_imm ? imm : rs2)});
    endtask

    // mode 0: result and op_done together; mode 1: stale result early, real
    // result later, op_done alone at the end (wait_cyc >= 2).
    task automatic run_op(input logic [OW-1:0] op, input logic [BW-1:0] rs1,
                          input logic [BW-1:0] rs2, input logic [BW-1:0] imm,
                          input logic use_imm, input logic [4:0] rd,
                          input int wait_cyc, input int mode, input int bp);
        logic [BW-1:0] a, b, res, held;
        logic [BW+4:0] exp;
        int lat, n;
        issue(op, rs1, rs2, imm, use_imm, rd, 1'b1);
        lat = 0;
        chk("rs1_valid", bus.rs_data_valid, 1);
        chk("rs1_sel", bus.rs_data_sel, RS_SEL_RS1);
        chk("rs1_data", bus.rs_data, rs1);
        chk("op_code", bus.op_code, op);
        chk("imme_value", bus.imme_value, imm);
        a = bus.rs_data;
        tick(); lat++;
        if (!use_imm) begin
            chk("rs2_valid", bus.rs_data_valid, 1);
            chk("rs2_sel", bus.rs_data_sel, RS_SEL_RS2);
            chk("rs2_data", bus.rs_data, rs2);
            b = bus.rs_data;
            tick(); lat++;
        end else begin
            b = bus.imme_value;
        end
        chk("wait_state", dbg_state, WAIT_ALU);
        chk("wait_rs_valid", bus.rs_data_valid, 0);
        chk("wait_rs_data", bus.rs_data, 0);
        chk("wait_imme_held", bus.imme_value, imm);
        res = alu_model(bus.op_code, a, b);
        for (int i = 0; i < wait_cyc; i++) begin
            bus.alu_valid_out = 1'b0;
            bus.alu_out       = '0;
            if (mode == 1 && i == 0) begin
                bus.alu_valid_out = 1'b1;
                bus.alu_out       = ~res;
            end
            if (mode == 1 && i == wait_cyc - 1) begin
                bus.alu_valid_out = 1'b1;
                bus.alu_out       = res;
            end
            tick(); lat++;
            chk("wait_busy", bus.busy, 1);
            chk("wait_no_wb", bus.wb_valid, 0);
        end
        bus.op_done       = 1'b1;
        bus.alu_valid_out = (mode == 0);
        bus.alu_out       = (mode == 0) ? res : 32'hDEAD_BEEF;
        tick(); lat++;
        bus.op_done       = 1'b0;
        bus.alu_valid_out = 1'b0;
        bus.alu_out       = '0;
        n = 0;
        while (bus.wb_valid !== 1'b1 && n < 8) begin
            tick(); lat++; n++;
        end
        chk("wb_latency", lat, (use_imm ? 2 : 3) + wait_cyc);
        chk("scoreboard_nonempty", exp_q.size() > 0, 1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk("wb_data", bus.wb_data, exp[BW-1:0]);
        chk("wb_rd", bus.wb_rd, exp[BW+4:BW]);
        held = bus.wb_data;
        for (int i = 0; i < bp; i++) begin
            bus.wb_ready = 1'b0;
            tick();
            chk("bp_wb_valid", bus.wb_valid, 1);
            chk("bp_wb_data", bus.wb_data, held);
            chk("bp_issue_ready", bus.issue_ready, 0);
        end
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
        chk("wb_drop", bus.wb_valid, 0);
        chk("ready_back", bus.issue_ready, 1);
        chk("no_err_timeout", bus.err_timeout, 0);
        chk("no_err_protocol", bus.err_protocol, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.issue_valid = 0; bus.issue_op_code = '0; bus.issue_rs1 = '0;
        bus.issue_rs2 = '0; bus.issue_imm = '0; bus.issue_use_imm = 0;
        bus.issue_rd = '0; bus.alu_out = '0; bus.alu_valid_out = 0;
        bus.op_done = 0; bus.wb_ready = 0;

        // reset state
        tick();
        chk("rst_issue_ready", bus.issue_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_rs_valid", bus.rs_data_valid, 0);
        chk("rst_errors", {bus.err_timeout, bus.err_protocol}, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", bus.issue_ready, 1);

        // register-register: 5 + 7 -> rd 3
        run_op(11'd1, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3, 0, 0, 0);
        // immediate: 0x10 + 0x4
        run_op(11'd1, 32'h10, 32'hFFFF, 32'h4, 1'b1, 5'd9, 0, 0, 0);
        // backpressure for 4 cycles
        run_op(11'd2, 32'd100, 32'd30, 32'd0, 1'b0, 5'd17, 0, 0, 4);
        // early results, last one wins, op_done alone
        run_op(11'd3, 32'hA5A5_0F0F, 32'h0F0F_A5A5, 32'd0, 1'b0, 5'd31, 3, 1, 0);
        // op_done on the last allowed WAIT_ALU cycle
        run_op(11'd1, 32'd1, 32'd0, 32'd2, 1'b1, 5'd4, TO - 1, 0, 0);

        // timeout: no op_done for TO cycles
        issue(11'd1, 32'd3, 32'd0, 32'd3, 1'b1, 5'd5, 1'b0);
        tick();
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            chk("to_still_waiting", dbg_state, WAIT_ALU);
            chk("to_err_low", bus.err_timeout, 0);
        end
        tick();
        chk("to_err_pulse", bus.err_timeout, 1);
        chk("to_no_wb", bus.wb_valid, 0);
        chk("to_idle", bus.busy, 0);
        tick();
        chk("to_err_one_cycle", bus.err_timeout, 0);

        // protocol: result offered outside WAIT_ALU is ignored
        issue(11'd1, 32'd8, 32'd0, 32'd1, 1'b1, 5'd6, 1'b0);
        bus.alu_valid_out = 1'b1; bus.alu_out = 32'h1234; bus.op_done = 1'b1;
        tick();
        chk("pr_in_wait", dbg_state, WAIT_ALU);
        bus.alu_valid_out = 1'b0; bus.alu_out = '0;
        tick();
        bus.op_done = 1'b0;
        chk("pr_err_pulse", bus.err_protocol, 1);
        chk("pr_no_wb", bus.wb_valid, 0);
        chk("pr_idle", bus.busy, 0);
        tick();
        chk("pr_err_one_cycle", bus.err_protocol, 0);

        // reset during SEND_RS2
        issue(11'd1, 32'd11, 32'd22, 32'd0, 1'b0, 5'd7, 1'b0);
        tick();
        chk("mid_in_rs2", dbg_state, SEND_RS2);
        rst = 1'b1;
        #1;
        chk("mid_rst_rs_valid", bus.rs_data_valid, 0);
        chk("mid_rst_rs_data", bus.rs_data, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_ready", bus.issue_ready, 0);
        chk("mid_rst_op_code", bus.op_code, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_no_wb", bus.wb_valid, 0);
        chk("mid_rst_no_err", {bus.err_timeout, bus.err_protocol}, 0);
        run_op(11'd1, 32'd11, 32'd22, 32'd0, 1'b0, 5'd7, 0, 0, 0);

        // randomized operations
        for (int k = 0; k < 8; k++) begin
            run_op(11'($urandom_range(1, 4)), $urandom, $urandom, $urandom,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   $urandom_range(2, 6), $urandom_range(0, 1), $urandom_range(0, 3));
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameters SHALL be: BUS_WIDTH, default 32, operand/result width; OPCODE_WIDTH, default 11, ALU opcode width; TIMEOUT_CYCLES, default 16, maximum cycles spent in WAIT_ALU.
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-high (clk, rst).
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  async active-high reset.
- issue_valid  in  1  decode offers instruction.
- issue_ready  out  1  controller accepts instruction.
- issue_op_code  in  OPCODE_WIDTH  ALU opcode.
- issue_rs1  in  BUS_WIDTH  first source operand.
- issue_rs2  in  BUS_WIDTH  second source operand.
- issue_imm  in  BUS_WIDTH  immediate operand.
- issue_use_imm  in  1  1 = rs1+imm, skip rs2 beat.
- issue_rd  in  5  destination register index.
- imme_value  out  BUS_WIDTH  immediate to ALU.
- rs_data  out  BUS_WIDTH  serialized source operand to ALU.
- rs_data_sel  out  1  0 = rs1 beat, 1 = rs2 beat.
- rs_data_valid  out  1  rs_data beat valid.
- op_code  out  OPCODE_WIDTH  opcode to ALU.
- alu_out  in  BUS_WIDTH  ALU result.
- alu_valid_out  in  1  alu_out valid.
- op_done  in  1  ALU finished current op.
- wb_valid  out  1  result offered to writeback.
- wb_ready  in  1  writeback accepts.
- wb_data  out  BUS_WIDTH  captured result.
- wb_rd  out  5  destination index.
- busy  out  1  state != IDLE.
- err_timeout  out  1  one-cycle pulse, ALU timeout.
- err_protocol  out  1  one-cycle pulse, op_done without result.

Function
REQ-004 FSM states SHALL be IDLE, SEND_RS1, SEND_RS2, WAIT_ALU, WB; all outputs registered or decoded from registered state only (Moore).
REQ-005 issue_ready SHALL be 1 only in IDLE; on issue_valid&&issue_ready, latch op_code, rs1, rs2, imm, use_imm, rd and go SEND_RS1.
REQ-006 op_code and imme_value SHALL reflect the latched instruction from SEND_RS1 until return to IDLE.
REQ-007 SEND_RS1: rs_data=rs1, rs_data_sel=0, rs_data_valid=1 for exactly one cycle; next state WAIT_ALU if use_imm, else SEND_RS2.
REQ-008 SEND_RS2: rs_data=rs2, rs_data_sel=1, rs_data_valid=1 for exactly one cycle; next WAIT_ALU.
REQ-009 rs_data_valid SHALL be 0 in every other state; rs_data and rs_data_sel SHALL be 0 when not valid.
REQ-010 WAIT_ALU: any cycle with alu_valid_out=1 loads alu_out into the result register (last one wins) and sets a result_seen flag.
REQ-011 WAIT_ALU with op_done=1: go WB if result_seen or alu_valid_out is 1 that cycle; otherwise pulse err_protocol, go IDLE, no writeback.
REQ-012 Wait counter SHALL clear on WAIT_ALU entry and increment per cycle with op_done=0; at count TIMEOUT_CYCLES-1 with op_done=0, pulse err_timeout and go IDLE, no writeback.
REQ-013 op_done in the same cycle as the timeout threshold SHALL win (no timeout).
REQ-014 WB: wb_valid=1 with wb_data, wb_rd held stable until wb_ready=1; then go IDLE; wb_valid falls the following cycle.
REQ-015 Minimum latency from accept edge to wb_valid high SHALL be 2 cycles (immediate) or 3 cycles (register-register).
REQ-016 alu_valid_out/op_done outside WAIT_ALU SHALL be ignored.
REQ-017 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1); TIMEOUT_CYCLES >= 2.

Reset
REQ-018 rst SHALL force state IDLE, clear latches, counter and flags, and set all outputs to 0, except issue_ready, which becomes 1 after rst deasserts.
REQ-019 rst mid-operation SHALL discard the in-flight instruction with no wb_valid and no error pulse.

Structure
REQ-020 Package alu_pkg SHALL hold the BUS_WIDTH/OPCODE_WIDTH defaults, the alu_ctrl_state_e enum and the constants RS_SEL_RS1=0, RS_SEL_RS2=1.
REQ-021 Timeout counter SHALL be sub-module alu_wait_timer (clear, enable, expired).
REQ-022 ALU-side port names SHALL match the ALU interface signals for direct binding.

Verification
REQ-023 Reg-reg: issue rs1=5, rs2=7, use_imm=0, rd=3 -> one beat each with sel 0 then 1; ALU returns 12 with op_done -> wb_data=12, wb_rd=3, 3 cycles after accept.
REQ-024 Immediate: rs1=0x10, imm=0x4, use_imm=1 -> single sel=0 beat, no rs2 beat, imme_value=0x4 held; wb after 2 cycles.
REQ-025 Backpressure: wb_ready held 0 for 4 cycles -> wb_valid/wb_data stable, issue_ready=0 throughout; accept on 5th.
REQ-026 Timeout: no op_done for 16 WAIT_ALU cycles -> err_timeout one-cycle pulse, no wb_valid, IDLE; op_done on the 16th cycle -> normal WB.
REQ-027 Protocol: op_done=1 with alu_valid_out never 1 -> err_protocol pulse, no writeback.
REQ-028 Reset in SEND_RS2 -> all outputs 0 immediately, no wb_valid, next issue proceeds normally.
